// File: rtl/stopwatch_sequencer.sv
// rtl/stopwatch_sequencer.sv - single-clock RUN/ADJ/PAUSE mode FSM and tick sequencer for the min/sec stopwatch
module stopwatch_sequencer #(
  parameter int unsigned RUN_DIV   = 100000000,
  parameter int unsigned ADJ_DIV   = 50000000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause_p,
  input  logic       clr_p,
  input  logic       adj,
  input  logic       sel,
  input  logic       at_max,
  output logic [1:0] mode,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       cnt_clr,
  output logic       blink
);

  localparam int RUN_W = $clog2(RUN_DIV);
  localparam int ADJ_W = $clog2(ADJ_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_ADJ   = 2'd1,
    MODE_PAUSE = 2'd2
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [ADJ_W-1:0] adj_cnt_q, adj_cnt_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             inc_sec_q, inc_sec_d;
  logic             inc_min_q, inc_min_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             blink_q, blink_d;

  logic enter_adj;
  logic run_tick;
  logic adj_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q        <= MODE_RUN;
      run_cnt_q     <= '0;
      adj_cnt_q     <= '0;
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b1;
      inc_sec_q     <= 1'b0;
      inc_min_q     <= 1'b0;
      cnt_clr_q     <= 1'b1;
      blink_q       <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      run_cnt_q     <= run_cnt_d;
      adj_cnt_q     <= adj_cnt_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
      inc_sec_q     <= inc_sec_d;
      inc_min_q     <= inc_min_d;
      cnt_clr_q     <= cnt_clr_d;
      blink_q       <= blink_d;
    end
  end

  // pause_p outranks adj in every state
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:   if (pause_p) mode_d = MODE_PAUSE; else if (adj) mode_d = MODE_ADJ;
      MODE_PAUSE: if (pause_p) mode_d = adj ? MODE_ADJ : MODE_RUN;
      MODE_ADJ:   if (pause_p) mode_d = MODE_PAUSE; else if (!adj) mode_d = MODE_RUN;
      default:    mode_d = MODE_RUN;
    endcase
  end

  always_comb begin
    enter_adj = (mode_d == MODE_ADJ) && (mode_q != MODE_ADJ);
    run_tick  = (mode_q == MODE_RUN) && (run_cnt_q == RUN_LAST);
    adj_tick  = (mode_q == MODE_ADJ) && (adj_cnt_q == ADJ_LAST);

    // run prescaler only advances on edges that start and end in RUN, so a paused partial second survives
    run_cnt_d = run_cnt_q;
    if (clr_p || enter_adj || run_tick) run_cnt_d = '0;
    else if ((mode_q == MODE_RUN) && (mode_d == MODE_RUN)) run_cnt_d = run_cnt_q + RUN_W'(1);

    adj_cnt_d = adj_cnt_q;
    if (enter_adj || adj_tick) adj_cnt_d = '0;
    else if (mode_q == MODE_ADJ) adj_cnt_d = adj_cnt_q + ADJ_W'(1);

    blk_cnt_d     = blk_cnt_q;
    blink_phase_d = blink_phase_q;
    if (enter_adj) begin
      blk_cnt_d     = '0;
      blink_phase_d = 1'b1;
    end else if (mode_q == MODE_ADJ) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d     = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end

    // a clear on the same edge as a tick swallows the tick
    inc_sec_d = !clr_p && ((run_tick && !at_max) || (adj_tick && sel));
    inc_min_d = !clr_p && adj_tick && !sel;
    cnt_clr_d = clr_p;
    blink_d   = (mode_d == MODE_ADJ) && blink_phase_d;
  end

  assign mode    = mode_q;
  assign inc_sec = inc_sec_q;
  assign inc_min = inc_min_q;
  assign cnt_clr = cnt_clr_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb/tb_stopwatch_sequencer.sv - scoreboard bench for stopwatch_sequencer with RUN_DIV=4, ADJ_DIV=3, BLINK_DIV=2
module tb_stopwatch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause_p = 1'b0;
  logic       clr_p = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       at_max = 1'b0;
  logic [1:0] mode;
  logic       inc_sec;
  logic       inc_min;
  logic       cnt_clr;
  logic       blink;

  int checks = 0;
  int fails  = 0;

  // observation word: {cnt_clr, inc_min, inc_sec, mode[1:0], blink}
  logic [5:0] exp_q[$];
  logic [5:0] obs;
  logic [5:0] e;

  stopwatch_sequencer #(
    .RUN_DIV  (4),
    .ADJ_DIV  (3),
    .BLINK_DIV(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pause_p(pause_p),
    .clr_p  (clr_p),
    .adj    (adj),
    .sel    (sel),
    .at_max (at_max),
    .mode   (mode),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .cnt_clr(cnt_clr),
    .blink  (blink)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] mk(input logic c, input logic mi, input logic s,
                                    input logic [1:0] m, input logic b);
    return {c, mi, s, m, b};
  endfunction

  function automatic logic blink_at(input int m);
    return (((m - 1) / 2) % 2) == 0;
  endfunction

  task automatic cycle(output logic [5:0] o);
    @(posedge clk);
    @(negedge clk);
    o = {cnt_clr, inc_min, inc_sec, mode, blink};
  endtask

  task automatic do_reset();
    logic [5:0] d;
    reset = 1'b1;
    pause_p = 1'b0; clr_p = 1'b0; adj = 1'b0; sel = 1'b0; at_max = 1'b0;
    cycle(d);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(obs);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    cycle(obs);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_state got clr/min/sec/mode/blink=%b want %b", obs, e);
    end
  endtask

  task automatic test_run();
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, (k % 4) == 0, 2'd0, 1'b0));
      cycle(obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL run k=%0d got clr/min/sec/mode/blink=%b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      pause_p = (k == 3) || (k == 14);
      exp_q.push_back(mk(1'b0, 1'b0, k == 16, (k >= 3 && k < 14) ? 2'd2 : 2'd0, 1'b0));
      cycle(obs);
      pause_p = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pause k=%0d got clr/min/sec/mode/blink=%b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_adjust();
    do_reset();
    adj = 1'b1;
    sel = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(mk(1'b0, (k > 1) && ((k - 1) % 3 == 0), 1'b0, 2'd1, blink_at(k)));
      cycle(obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL adjust k=%0d got clr/min/sec/mode/blink=%b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_adjust_sel_exit();
    sel = 1'b1;
    for (int k = 13; k <= 22; k++) begin
      adj = (k < 14);
      if (k == 13) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 2'd1, 1'b1));
      else         exp_q.push_back(mk(1'b0, 1'b0, (k == 18) || (k == 22), 2'd0, 1'b0));
      cycle(obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL adjust_sel_exit k=%0d got clr/min/sec/mode/blink=%b want %b", k, obs, e);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_at_max_clear();
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      at_max = (k <= 20);
      clr_p  = (k == 24);
      exp_q.push_back(mk(k == 24, 1'b0, k == 28, 2'd0, 1'b0));
      cycle(obs);
      clr_p = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL at_max_clear k=%0d got clr/min/sec/mode/blink=%b want %b", k, obs, e);
      end
    end
    at_max = 1'b0;
  endtask

  task automatic test_pause_priority();
    do_reset();
    adj = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      pause_p = (k == 1) || (k == 6);
      exp_q.push_back(mk(1'b0, k == 9, 1'b0, (k < 6) ? 2'd2 : 2'd1,
                         (k >= 6) && blink_at(k - 5)));
      cycle(obs);
      pause_p = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pause_priority k=%0d got clr/min/sec/mode/blink=%b want %b", k, obs, e);
      end
    end
    adj = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_adjust();
    test_adjust_sel_exit();
    test_at_max_clear();
    test_pause_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
